// File: rtl/err_sweep_if.sv
// Bus between the error-sweep controller and its environment: sweep control,
// the operand/sum loop to the external approximate adder, and the results.
interface err_sweep_if #(
  parameter int WIDTH = 8
) ();
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH:0]     approx_sum;
  logic               busy;
  logic               done;
  logic [3*WIDTH:0]   err_sum;
  logic [WIDTH:0]     err_max;
  logic [2*WIDTH:0]   err_cnt;

  // Controller side: drives operands and results, receives control and sum.
  modport master (
    input  start, abort, approx_sum,
    output op_a, op_b, busy, done, err_sum, err_max, err_cnt
  );

  // Environment side: drives control and the adder's sum, observes the rest.
  modport slave (
    output start, abort, approx_sum,
    input  op_a, op_b, busy, done, err_sum, err_max, err_cnt
  );
endinterface

// File: rtl/err_sweep_ctrl.sv
// Exhaustive error characterisation of an external approximate adder.
// Walks every (op_a, op_b) pair, compares the returned sum against the exact
// sum and accumulates total, maximum and count of non-zero absolute errors.
//
// Handshake: start is accepted only in IDLE (level sampled at the edge, no
// ready needed since IDLE is the only accepting state); abort is honoured only
// in SWEEP/DRAIN. Inside the datapath err_q is qualified by err_v: err_q is
// consumed into the accumulators on the edge after it was produced, exactly
// once, unless an abort discards it.
module err_sweep_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  err_sweep_if.master bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] OP_MAX = '1;

  state_t            state;
  state_t            state_nxt;

  logic [WIDTH-1:0]  op_a_q;
  logic [WIDTH-1:0]  op_b_q;
  logic [WIDTH:0]    err_q;
  logic              err_v;
  logic [3*WIDTH:0]  sum_q;
  logic [WIDTH:0]    max_q;
  logic [2*WIDTH:0]  cnt_q;

  logic              last_pair;
  logic [WIDTH:0]    exact;
  logic [WIDTH:0]    err_now;
  logic              clear;
  logic              step;
  logic              acc;

  // Error of the pair currently on the operand bus, without wrap.
  always_comb begin
    last_pair = (op_a_q == OP_MAX) && (op_b_q == OP_MAX);
    exact     = {1'b0, op_a_q} + {1'b0, op_b_q};
    if (exact >= bus.approx_sum) begin
      err_now = exact - bus.approx_sum;
    end else begin
      err_now = bus.approx_sum - exact;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    step      = 1'b0;
    acc       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_SWEEP;
          clear     = 1'b1;
        end
      end
      S_SWEEP: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else begin
          step = 1'b1;
          acc  = err_v;
          if (last_pair) begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else begin
          acc       = err_v;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand counter: op_b is the fast digit, op_a the slow one; holds on last pair.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (step && !last_pair) begin
      op_b_q <= op_b_q + 1'b1;
      if (op_b_q == OP_MAX) begin
        op_a_q <= op_a_q + 1'b1;
      end
    end
  end

  // Error pipeline stage; valid drops whenever nothing new is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      err_q <= '0;
      err_v <= 1'b0;
    end else if (step) begin
      err_q <= err_now;
      err_v <= 1'b1;
    end else begin
      err_v <= 1'b0;
    end
  end

  // Accumulators; widths cover the worst case so no saturation is needed.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sum_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (acc) begin
      sum_q <= sum_q + {{(2*WIDTH){1'b0}}, err_q};
      if (err_q > max_q) begin
        max_q <= err_q;
      end
      if (err_q != '0) begin
        cnt_q <= cnt_q + {{(2*WIDTH){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.op_a    = op_a_q;
  assign bus.op_b    = op_b_q;
  assign bus.busy    = (state == S_SWEEP) || (state == S_DRAIN);
  assign bus.done    = (state == S_DONE);
  assign bus.err_sum = sum_q;
  assign bus.err_max = max_q;
  assign bus.err_cnt = cnt_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_err_sweep_ctrl.sv
// Bench for err_sweep_ctrl with a small operand width so full sweeps are short.
module tb_err_sweep_ctrl;
  localparam int W = 4;
  localparam int N = 1 << (2 * W);
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  err_sweep_if #(.WIDTH(W)) bus ();
  err_sweep_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Adder stub: 0 exact, 1 exact+1, 2 constant zero, 3 random table per pair.
  int mode = 0;
  logic noise = 1'b0;
  logic [W:0] garbage;
  logic [W:0] lut [N];

  always @(posedge clk) garbage <= (W+1)'($urandom_range(0, (1 << (W+1)) - 1));

  always_comb begin
    int ia;
    int ib;
    ia = int'(bus.op_a);
    ib = int'(bus.op_b);
    bus.approx_sum = (W+1)'(ia + ib);
    if (noise && !bus.busy) begin
      bus.approx_sum = garbage;
    end else begin
      case (mode)
        1: bus.approx_sum = (W+1)'(ia + ib + 1);
        2: bus.approx_sum = '0;
        3: bus.approx_sum = lut[ia * M + ib];
        default: bus.approx_sum = (W+1)'(ia + ib);
      endcase
    end
  end

  // Reference: absolute error of pair number idx in sweep order.
  function automatic int ref_err(int idx, int m);
    int a;
    int b;
    int apx;
    int e;
    a = idx / M;
    b = idx % M;
    case (m)
      1: apx = a + b + 1;
      2: apx = 0;
      3: apx = int'(lut[idx]);
      default: apx = a + b;
    endcase
    e = (a + b) - apx;
    return (e < 0) ? -e : e;
  endfunction

  // Totals over the first n pairs of the sweep.
  task automatic model(input int n, input int m, output logic [3*W:0] s,
                       output logic [W:0] mx, output logic [2*W:0] c);
    longint ls = 0;
    int lm = 0;
    int lc = 0;
    for (int i = 0; i < n; i++) begin
      int e;
      e = ref_err(i, m);
      ls += e;
      if (e > lm) lm = e;
      if (e != 0) lc++;
    end
    s  = (3*W+1)'(ls);
    mx = (W+1)'(lm);
    c  = (2*W+1)'(lc);
  endtask

  // Starts a sweep from IDLE (call #1 after an edge) and waits for done.
  task automatic run_sweep(output int lat, output logic [3*W:0] s,
                           output logic [W:0] mx, output logic [2*W:0] c);
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!noise) bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < N + 20) begin
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    s  = bus.err_sum;
    mx = bus.err_max;
    c  = bus.err_cnt;
  endtask

  task automatic test_reset;
    int lat;
    logic [3*W:0] s, es;
    logic [W:0] mx, em;
    logic [2*W:0] c, ec;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.op_a !== '0 || bus.op_b !== '0) begin
      errors++; $display("FAIL reset_ops got %0d,%0d want 0,0", bus.op_a, bus.op_b);
    end
    checks++;
    if (bus.err_sum !== '0 || bus.err_max !== '0 || bus.err_cnt !== '0) begin
      errors++; $display("FAIL reset_results got %0d %0d %0d want 0 0 0",
                         bus.err_sum, bus.err_max, bus.err_cnt);
    end
    // First edge out of reset with start high must start the sweep.
    bus.abort = 1'b0;
    rst_n = 1'b1;
    mode = 0;
    run_sweep(lat, s, mx, c);
    model(N, 0, es, em, ec);
    checks++;
    if (lat !== N + 2) begin
      errors++; $display("FAIL first_start_latency got %0d want %0d", lat, N + 2);
    end
    checks++;
    if (s !== es || mx !== em || c !== ec) begin
      errors++; $display("FAIL first_start_results got %0d %0d %0d want %0d %0d %0d",
                         s, mx, c, es, em, ec);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exact;
    int lat;
    logic [3*W:0] s, es;
    logic [W:0] mx, em;
    logic [2*W:0] c, ec;
    mode = 0;
    run_sweep(lat, s, mx, c);
    model(N, 0, es, em, ec);
    checks++;
    if (lat !== N + 2) begin
      errors++; $display("FAIL exact_latency got %0d want %0d", lat, N + 2);
    end
    checks++;
    if (s !== es || mx !== em || c !== ec) begin
      errors++; $display("FAIL exact_results got %0d %0d %0d want %0d %0d %0d",
                         s, mx, c, es, em, ec);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL exact_busy_in_done got %b want 0", bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.err_sum !== es || bus.err_cnt !== ec) begin
        errors++; $display("FAIL exact_hold_idle done=%b sum=%0d cnt=%0d want 0 %0d %0d",
                           bus.done, bus.err_sum, bus.err_cnt, es, ec);
      end
    end
  endtask

  task automatic test_plus_one;
    int lat;
    logic [3*W:0] s, es;
    logic [W:0] mx, em;
    logic [2*W:0] c, ec;
    mode = 1;
    run_sweep(lat, s, mx, c);
    model(N, 1, es, em, ec);
    checks++;
    if (lat !== N + 2 || s !== es || mx !== em || c !== ec) begin
      errors++; $display("FAIL plus_one lat=%0d res=%0d %0d %0d want %0d %0d %0d %0d",
                         lat, s, mx, c, N + 2, es, em, ec);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int lat;
    logic [3*W:0] s, es;
    logic [W:0] mx, em;
    logic [2*W:0] c, ec;
    mode = 2;
    run_sweep(lat, s, mx, c);
    model(N, 2, es, em, ec);
    checks++;
    if (lat !== N + 2 || s !== es || mx !== em || c !== ec) begin
      errors++; $display("FAIL zero_sum lat=%0d res=%0d %0d %0d want %0d %0d %0d %0d",
                         lat, s, mx, c, N + 2, es, em, ec);
    end
    @(posedge clk); #1;
  endtask

  // Random adder table, random start toggling while busy, garbage sums in IDLE/DONE.
  task automatic test_random;
    int lat;
    logic [3*W:0] s, es;
    logic [W:0] mx, em;
    logic [2*W:0] c, ec;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) lut[i] = (W+1)'($urandom_range(0, (1 << (W+1)) - 1));
      mode = 3;
      noise = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      run_sweep(lat, s, mx, c);
      model(N, 3, es, em, ec);
      checks++;
      if (lat !== N + 2 || s !== es || mx !== em || c !== ec) begin
        errors++; $display("FAIL random_%0d lat=%0d res=%0d %0d %0d want %0d %0d %0d %0d",
                           r, lat, s, mx, c, N + 2, es, em, ec);
      end
      noise = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // start held high: checks operand order, DRAIN/DONE/IDLE spacing and restart.
  task automatic test_sequence;
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] e;
    int dones;
    mode = 0;
    for (int i = 0; i < N; i++) exp_q.push_back((2*W)'(i));
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= N; cyc++) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.op_a, bus.op_b} !== e || bus.busy !== 1'b1) begin
        errors++; $display("FAIL seq_pair cycle %0d got %0d,%0d busy=%b want %0d,%0d busy=1",
                           cyc, bus.op_a, bus.op_b, bus.busy, e / M, e % M);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.op_a !== W'(M - 1) || bus.op_b !== W'(M - 1)) begin
      errors++; $display("FAIL seq_drain busy=%b done=%b ops=%0d,%0d want 1 0 %0d,%0d",
                         bus.busy, bus.done, bus.op_a, bus.op_b, M - 1, M - 1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL seq_done done=%b busy=%b want 1 0", bus.done, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL seq_idle done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.op_a !== '0 || bus.op_b !== '0 || bus.err_cnt !== '0) begin
      errors++; $display("FAIL seq_restart busy=%b ops=%0d,%0d cnt=%0d want 1 0,0 0",
                         bus.busy, bus.op_a, bus.op_b, bus.err_cnt);
    end
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < N + 10; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL seq_done_count got %0d busy=%b want 1 0", dones, bus.busy);
    end
  endtask

  task automatic test_abort;
    int k;
    int lat;
    int dones;
    logic [3*W:0] s, es;
    logic [W:0] mx, em;
    logic [2*W:0] c, ec;
    mode = 2;
    k = $urandom_range(50, 200);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (k) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    model(k - 1, 2, es, em, ec);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_idle busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.err_sum !== es || bus.err_max !== em || bus.err_cnt !== ec) begin
      errors++; $display("FAIL abort_partial k=%0d got %0d %0d %0d want %0d %0d %0d",
                         k, bus.err_sum, bus.err_max, bus.err_cnt, es, em, ec);
    end
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones !== 0 || bus.err_cnt !== ec) begin
      errors++; $display("FAIL abort_quiet activity=%0d cnt=%0d want 0 %0d", dones, bus.err_cnt, ec);
    end
    // abort together with start in IDLE: start wins, sweep completes normally.
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    lat = 1;
    while (!bus.done && lat < N + 20) begin
      bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    model(N, 2, es, em, ec);
    checks++;
    if (lat !== N + 2 || bus.err_sum !== es || bus.err_max !== em || bus.err_cnt !== ec) begin
      errors++; $display("FAIL abort_start_wins lat=%0d res=%0d %0d %0d want %0d %0d %0d %0d",
                         lat, bus.err_sum, bus.err_max, bus.err_cnt, N + 2, es, em, ec);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [3*W:0] s, es;
    logic [W:0] mx, em;
    logic [2*W:0] c, ec;
    mode = 2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat ($urandom_range(20, 200)) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.op_a !== '0 || bus.op_b !== '0 ||
        bus.err_sum !== '0 || bus.err_max !== '0 || bus.err_cnt !== '0) begin
      errors++; $display("FAIL reset_mid busy=%b done=%b ops=%0d,%0d res=%0d %0d %0d want all 0",
                         bus.busy, bus.done, bus.op_a, bus.op_b, bus.err_sum, bus.err_max, bus.err_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stays_idle busy=%b want 0", bus.busy);
    end
    mode = 0;
    run_sweep(lat, s, mx, c);
    model(N, 0, es, em, ec);
    checks++;
    if (lat !== N + 2 || s !== es || mx !== em || c !== ec) begin
      errors++; $display("FAIL reset_mid_rerun lat=%0d res=%0d %0d %0d want %0d %0d %0d %0d",
                         lat, s, mx, c, N + 2, es, em, ec);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) lut[i] = '0;
    test_reset();
    test_exact();
    test_plus_one();
    test_zero();
    test_random();
    test_sequence();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/err_sweep_ctrl.md
ERR_SWEEP_CTRL -- requirements
Module: err_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width of the approximate adder under characterisation; legal range 2..12.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a full exhaustive sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate a running sweep.
REQ-006 op_a  output  WIDTH  first operand driven to the external approximate adder, registered.
REQ-007 op_b  output  WIDTH  second operand driven to the external approximate adder, registered.
REQ-008 approx_sum  input  WIDTH+1  combinational sum returned by the external adder for the current op_a/op_b.
REQ-009 busy  output  1  high in SWEEP and DRAIN.
REQ-010 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-011 err_sum  output  3*WIDTH+1  accumulated absolute error over all pairs.
REQ-012 err_max  output  WIDTH+1  largest absolute error seen.
REQ-013 err_cnt  output  2*WIDTH+1  number of pairs with non-zero error.

Function
REQ-014 FSM states: IDLE, SWEEP, DRAIN, DONE; encoding free.
REQ-015 IDLE with start=1: next state SWEEP; op_a, op_b, err_sum, err_max, err_cnt and internal error pipeline cleared to 0.
REQ-016 Each SWEEP cycle: exact = zero-extended op_a + zero-extended op_b (WIDTH+1 bits); err = |exact - approx_sum|, computed without wrap, registered with a valid flag.
REQ-017 Registered valid err accumulated the following cycle: err_sum += err; err_max = max(err_max, err); err_cnt += 1 if err != 0.
REQ-018 Operand order: op_b increments every SWEEP cycle; on op_b wrap from 2^WIDTH-1 to 0, op_a increments.
REQ-019 SWEEP with op_a = op_b = 2^WIDTH-1: pair is evaluated, next state DRAIN, operands hold.
REQ-020 DRAIN lasts exactly one cycle: final pending err accumulated, next state DONE.
REQ-021 DONE lasts one cycle with done=1, busy=0; next state IDLE.
REQ-022 Latency: N = 2^(2*WIDTH) pairs; done high in cycle N+2 after the start-sampling edge (SWEEP N cycles, DRAIN 1); results final and stable while done is high.
REQ-023 Results hold their values in IDLE until the next accepted start.
REQ-024 Accumulator widths are sized so no overflow occurs for any approx_sum; no saturation logic required.
REQ-025 start while busy or in DONE: ignored, no restart, no effect on results.
REQ-026 abort in SWEEP or DRAIN: next state IDLE, done not asserted, pending err discarded, results keep partial values; abort in IDLE/DONE ignored.
REQ-027 abort and start asserted together in IDLE: start wins (abort ignored in IDLE).
REQ-028 approx_sum is sampled only in SWEEP; its value in other states has no effect.

Reset
REQ-029 rst_n=0 at a rising edge: state IDLE; op_a, op_b, err_sum, err_max, err_cnt = 0; busy=0, done=0; pending err invalid.
REQ-030 Reset mid-sweep takes priority over start/abort and discards all partial results.
REQ-031 First start accepted on the first edge with rst_n=1 and start=1.

Verification
REQ-032 WIDTH=8, approx_sum = op_a+op_b (exact stub), start pulse -> done after 65537 edges +1 cycle, err_sum=0, err_max=0, err_cnt=0.
REQ-033 WIDTH=8, approx_sum = op_a+op_b+1 -> err_sum=65536, err_max=1, err_cnt=65536.
REQ-034 WIDTH=8, approx_sum = 0 -> err_sum=16711680, err_max=510, err_cnt=65535.
REQ-035 WIDTH=2, exact stub, start held high continuously -> op sequence (0,0),(0,1)..(3,3), done pulses once per sweep, restart only from IDLE, busy low during DONE cycle.
REQ-036 WIDTH=8, abort after 100 SWEEP cycles with approx_sum=0 -> IDLE next cycle, no done, err_cnt<=99 partial, next start clears and completes normally.
REQ-037 rst_n=0 for one edge mid-sweep -> all outputs 0 next cycle, state IDLE, subsequent start produces REQ-032 results.
